// File: rtl/core_loader_pkg.sv
// core_loader_pkg
//   Shared types and default sizing for the boot-time program loader.
//   The default image sizes match the instruction/data RAM depth used by
//   CoreTop, so both sides size their memories from the same constants.
package core_loader_pkg;

    // Loader FSM states. IDLE is the reset state; RUN means the core is
    // out of reset and executing the loaded image.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_INST = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    localparam int DEF_INST_WORDS = 1024;
    localparam int DEF_DATA_WORDS = 1024;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_RST_HOLD   = 4;

endpackage

// File: rtl/core_loader.sv
// core_loader
//   Streams a program image into the core's RAMs at boot. The first
//   INST_WORDS accepted words go to the instruction RAM, the next
//   DATA_WORDS words go to the four byte-lane data RAMs (all lanes written
//   together). The core is held in reset until the image is written plus
//   RST_HOLD cycles, then released. A start pulse in RUN reloads the image.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   start             : one-cycle pulse, begins a load (IDLE or RUN only)
//   s_valid/s_data    : image word stream
//   s_ready           : high in LOAD_INST/LOAD_DATA, from state only
//   inst_we/addr/wdata: instruction RAM write port (registered)
//   data_we/addr/wdata: data RAM write port, data_we bit n -> lane n,
//                       lane n takes data_wdata[8n+7:8n] (registered)
//   core_rst          : reset to CoreTop, low only in RUN
//   busy              : high in LOAD_INST, LOAD_DATA and HOLD
//   done              : high only in RUN
//
// Handshake: a word is transferred on a rising clk edge where
// s_valid && s_ready. s_ready never depends on s_valid; the producer may
// stall s_valid for any number of cycles. Each transfer produces exactly
// one single-cycle RAM write strobe in the following cycle.
module core_loader
    import core_loader_pkg::*;
#(
    parameter int INST_WORDS = DEF_INST_WORDS,
    parameter int DATA_WORDS = DEF_DATA_WORDS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RST_HOLD   = DEF_RST_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              inst_we,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_wdata,
    output logic [3:0]        data_we,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [ADDR_W-1:0] INST_LAST = ADDR_W'(INST_WORDS - 1);
    localparam logic [ADDR_W-1:0] DATA_LAST = ADDR_W'(DATA_WORDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic                inst_we_q, inst_we_d;
    logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
    logic [31:0]         inst_wdata_q, inst_wdata_d;
    logic [3:0]          data_we_q, data_we_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [31:0]         data_wdata_q, data_wdata_d;
    logic                core_rst_q, core_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                hs;

    assign s_ready = (state_q == ST_LOAD_INST) || (state_q == ST_LOAD_DATA);
    assign hs      = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    state_d    = ST_LOAD_INST;
                    word_cnt_d = '0;
                end
            end
            ST_LOAD_INST: begin
                if (hs) begin
                    if (word_cnt_q == INST_LAST) begin
                        state_d    = ST_LOAD_DATA;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (hs) begin
                    if (word_cnt_q == DATA_LAST) begin
                        state_d    = ST_HOLD;
                        word_cnt_d = '0;
                        hold_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // HOLD lasts exactly RST_HOLD cycles; the final data write
                // retires in its first cycle.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                word_cnt_d = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Write port registers: address/data only move on a transfer, strobes
    // are valid for the single cycle after it.
    always_comb begin
        inst_we_d    = hs && (state_q == ST_LOAD_INST);
        inst_addr_d  = inst_addr_q;
        inst_wdata_d = inst_wdata_q;
        data_we_d    = {4{hs && (state_q == ST_LOAD_DATA)}};
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;

        if (inst_we_d) begin
            inst_addr_d  = word_cnt_q;
            inst_wdata_d = s_data;
        end
        if (data_we_d[0]) begin
            data_addr_d  = word_cnt_q;
            data_wdata_d = s_data;
        end

        // Status flags are registered from the next state so they change
        // on the same edge as the state itself.
        core_rst_d = (state_d != ST_RUN);
        busy_d     = (state_d == ST_LOAD_INST) || (state_d == ST_LOAD_DATA) ||
                     (state_d == ST_HOLD);
        done_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            inst_we_q    <= 1'b0;
            inst_addr_q  <= '0;
            inst_wdata_q <= '0;
            data_we_q    <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            inst_we_q    <= inst_we_d;
            inst_addr_q  <= inst_addr_d;
            inst_wdata_q <= inst_wdata_d;
            data_we_q    <= data_we_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign inst_we    = inst_we_q;
    assign inst_addr  = inst_addr_q;
    assign inst_wdata = inst_wdata_q;
    assign data_we    = data_we_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
